event_pulse_stretcher: RTL and testbench

Output-side counterpart to switch input conditioning. Converts short internal event strobes (fault flags, threshold crossings, sample-ready ticks) into human-visible LED pulses with guaranteed minimum on-time and off-gap. Events that arrive while a pulse is in progress are queued in a saturating counter, so each event gets its own pulse. Sits between DSP/status logic and board LED pins.

---
 rtl/event_pulse_pkg.sv | 17 +
 rtl/pulse_timer.sv | 27 ++
 rtl/event_pulse_stretcher.sv | 142 ++++++++++++++
 tb/tb_event_pulse_stretcher.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_pulse_pkg.sv
// Shared types and helpers for the event pulse stretcher.
package event_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } pulse_state_t;

  // Converts a duration in ms to clock cycles; 64-bit product avoids overflow at high clock rates.
  function automatic int unsigned ms_to_cycles(input int unsigned freq_hz, input int unsigned ms);
    longint unsigned prod;
    prod = 64'(freq_hz) * 64'(ms);
    return 32'(prod / 64'd1000);
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter shared by the ON and GAP phases; done_c flags a count of zero.
module pulse_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done_c
);

  logic [W-1:0] count;

  // Load on strobe, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done_c = (count == '0);

endmodule

// File: rtl/event_pulse_stretcher.sv
// Stretches single-cycle event strobes into LED pulses with a minimum on-time and off-gap,
// queueing events that arrive mid-pulse in a saturating counter.
module event_pulse_stretcher
  import event_pulse_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned ON_TIME_MS  = 50,
  parameter int unsigned OFF_TIME_MS = 50,
  parameter int unsigned MAX_PENDING = 15
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               event_in,
  input  logic                               clear_overflow,
  output logic                               led_out,
  output logic                               busy,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending_count,
  output logic                               overflow
);

  localparam int unsigned ON_CYCLES  = ms_to_cycles(CLK_FREQ_HZ, ON_TIME_MS);
  localparam int unsigned OFF_CYCLES = ms_to_cycles(CLK_FREQ_HZ, OFF_TIME_MS);
  localparam int unsigned MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned TW         = $clog2(MAX_CYCLES + 1);
  localparam int unsigned CW         = $clog2(MAX_PENDING + 1);

  // Timer is loaded with N-1 so that the phase lasts exactly N cycles including the load cycle.
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [CW-1:0] PEND_MAX = CW'(MAX_PENDING);

  if (ON_CYCLES == 0) begin : g_on_check
    $error("event_pulse_stretcher: ON_CYCLES must be at least 1");
  end
  if (OFF_CYCLES == 0) begin : g_off_check
    $error("event_pulse_stretcher: OFF_CYCLES must be at least 1");
  end
  if (MAX_PENDING == 0) begin : g_pend_check
    $error("event_pulse_stretcher: MAX_PENDING must be at least 1");
  end

  pulse_state_t  state;
  pulse_state_t  state_next;
  logic          event_d;
  logic          ev_c;
  logic          consume_c;
  logic          timer_done_c;
  logic          timer_load;
  logic [TW-1:0] timer_value;
  logic          led_next;
  logic          busy_next;
  logic [CW-1:0] pending_next;
  logic          overflow_next;

  assign ev_c = event_in & ~event_d;

  pulse_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_value),
    .done_c     (timer_done_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a pending or same-cycle event restarts ON straight from the end of GAP.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (ev_c) state_next = ON;
      ON:   if (timer_done_c) state_next = GAP;
      GAP:  if (timer_done_c) state_next = ((pending_count != '0) || ev_c) ? ON : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output/datapath logic: timer loads, queue accounting and sticky overflow.
  always_comb begin
    timer_load    = 1'b0;
    timer_value   = '0;
    pending_next  = pending_count;
    overflow_next = overflow;
    consume_c     = (state == GAP) && (state_next == ON);
    led_next      = (state_next == ON);
    busy_next     = (state_next != IDLE);

    if ((state_next != state) && (state_next != IDLE)) begin
      timer_load  = 1'b1;
      timer_value = (state_next == ON) ? ON_LOAD : OFF_LOAD;
    end

    if (state == IDLE) begin
      pending_next = '0;
    end else if (consume_c) begin
      // A same-cycle event either replaces the consumed one or is itself consumed.
      if (!ev_c && (pending_count != '0)) begin
        pending_next = pending_count - CW'(1);
      end
    end else if (ev_c) begin
      if (pending_count == PEND_MAX) begin
        overflow_next = 1'b1;
      end else begin
        pending_next = pending_count + CW'(1);
      end
    end

    if (clear_overflow && (overflow_next == overflow)) begin
      overflow_next = 1'b0;
    end
    if ((state != IDLE) && !consume_c && ev_c && (pending_count == PEND_MAX)) begin
      overflow_next = 1'b1;
    end
  end

  // Registered outputs and the event edge-detect flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_d       <= 1'b0;
      led_out       <= 1'b0;
      busy          <= 1'b0;
      pending_count <= '0;
      overflow      <= 1'b0;
    end else begin
      event_d       <= event_in;
      led_out       <= led_next;
      busy          <= busy_next;
      pending_count <= pending_next;
      overflow      <= overflow_next;
    end
  end

endmodule

// File: tb/tb_event_pulse_stretcher.sv
// Self-checking bench for event_pulse_stretcher against a pulse-schedule reference model.
module tb_event_pulse_stretcher;

  localparam int ON   = 4;
  localparam int OFF  = 3;
  localparam int MAXP = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       event_in;
  logic       clear_overflow;
  logic       led_out;
  logic       busy;
  logic [1:0] pending_count;
  logic       overflow;

  event_pulse_stretcher #(
    .CLK_FREQ_HZ (1000),
    .ON_TIME_MS  (4),
    .OFF_TIME_MS (3),
    .MAX_PENDING (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .event_in       (event_in),
    .clear_overflow (clear_overflow),
    .led_out        (led_out),
    .busy           (busy),
    .pending_count  (pending_count),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: each accepted event has an arrival cycle and a scheduled pulse start.
  int         acc_a[$];
  int         acc_s[$];
  int         last_s;
  logic       prev_in;
  logic       m_ovf;
  logic [4:0] exp_vec;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void model_reset();
    acc_a.delete();
    acc_s.delete();
    last_s  = -1000;
    prev_in = 1'b0;
    m_ovf   = 1'b0;
  endfunction

  // Drives one cycle of inputs, computes the expected outputs for that cycle, then
  // folds this cycle's inputs into the schedule. Returns at the falling edge.
  task automatic step(input logic e, input logic c);
    int   t;
    int   n;
    int   ep;
    int   s;
    logic el;
    logic eb;
    logic ev;
    logic drop;
    @(posedge clk);
    #1;
    event_in       = e;
    clear_overflow = c;
    t  = cyc;
    el = 1'b0;
    eb = 1'b0;
    ep = 0;
    foreach (acc_s[i]) begin
      if (acc_s[i] <= t && t < acc_s[i] + ON) el = 1'b1;
      if (acc_s[i] <= t && t < acc_s[i] + ON + OFF) eb = 1'b1;
      if (acc_a[i] < t && acc_s[i] > t) ep++;
    end
    exp_vec = {el, eb, 2'(ep), m_ovf};
    ev      = e & ~prev_in;
    prev_in = e;
    drop    = 1'b0;
    if (ev) begin
      n = 0;
      foreach (acc_s[i]) if (acc_a[i] < t && acc_s[i] > t + 1) n++;
      if (n < MAXP) begin
        s = (t + 1 > last_s + ON + OFF) ? t + 1 : last_s + ON + OFF;
        acc_a.push_back(t);
        acc_s.push_back(s);
        last_s = s;
      end else begin
        drop = 1'b1;
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    event_in = 1'b0;
    clear_overflow = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({led_out, busy, pending_count, overflow} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset outputs got %b expected 00000", {led_out, busy, pending_count, overflow});
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    logic [4:0] obs;
    int led_cycles = 0;
    for (int k = 0; k < 22; k++) begin
      step(k == 10, 1'b0);
      obs = {led_out, busy, pending_count, overflow};
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL single k=%0d got %b expected %b", k, obs, exp_vec);
      end
      if (led_out === 1'b1) led_cycles++;
      if (k == 17 || k == 18) begin
        n_tests++;
        if (busy !== (k == 17)) begin
          n_fail++;
          $display("FAIL single_busy_fall k=%0d got %b expected %b", k, busy, (k == 17));
        end
      end
    end
    n_tests++;
    if (led_cycles != ON) begin
      n_fail++;
      $display("FAIL single_on_time got %0d expected %0d", led_cycles, ON);
    end
  endtask

  task automatic test_queue();
    logic [63:0] pat = 64'h154;
    logic [4:0]  obs;
    logic        led_q = 1'b0;
    int          max_pend = 0;
    int          pulses = 0;
    for (int k = 0; k < 40; k++) begin
      step(pat[k], 1'b0);
      obs = {led_out, busy, pending_count, overflow};
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL queue k=%0d got %b expected %b", k, obs, exp_vec);
      end
      if (int'(pending_count) > max_pend) max_pend = int'(pending_count);
      if (led_out === 1'b1 && !led_q) pulses++;
      led_q = led_out;
    end
    n_tests++;
    if (max_pend != 3 || pulses != 4) begin
      n_fail++;
      $display("FAIL queue_depth got max=%0d pulses=%0d expected max=3 pulses=4", max_pend, pulses);
    end
  endtask

  task automatic test_saturation();
    logic [63:0] pat = 64'h1554;
    logic [63:0] clr = 64'h10000;
    logic [4:0]  obs;
    for (int k = 0; k < 45; k++) begin
      step(pat[k], clr[k]);
      obs = {led_out, busy, pending_count, overflow};
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL saturation k=%0d got %b expected %b", k, obs, exp_vec);
      end
      if (k == 15) begin
        n_tests++;
        if (overflow !== 1'b1 || pending_count !== 2'd3) begin
          n_fail++;
          $display("FAIL sat_set got ovf=%b pend=%0d expected ovf=1 pend=3", overflow, pending_count);
        end
      end
      if (k == 17) begin
        n_tests++;
        if (overflow !== 1'b0 || pending_count !== 2'd2 || led_out !== 1'b1) begin
          n_fail++;
          $display("FAIL sat_clear got ovf=%b pend=%0d led=%b expected ovf=0 pend=2 led=1",
                   overflow, pending_count, led_out);
        end
      end
    end
  endtask

  task automatic test_held();
    logic [63:0] pat = 64'h3FFFFC;
    logic [4:0]  obs;
    logic        led_q = 1'b0;
    int          pulses = 0;
    int          max_pend = 0;
    for (int k = 0; k < 32; k++) begin
      step(pat[k], 1'b0);
      obs = {led_out, busy, pending_count, overflow};
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL held k=%0d got %b expected %b", k, obs, exp_vec);
      end
      if (led_out === 1'b1 && !led_q) pulses++;
      led_q = led_out;
      if (int'(pending_count) > max_pend) max_pend = int'(pending_count);
    end
    n_tests++;
    if (pulses != 1 || max_pend != 0) begin
      n_fail++;
      $display("FAIL held_single got pulses=%0d max_pend=%0d expected pulses=1 max_pend=0", pulses, max_pend);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] pat = 64'h154;
    logic [4:0]  obs;
    int          led_cycles = 0;
    for (int k = 0; k < 12; k++) begin
      step(pat[k], 1'b0);
      obs = {led_out, busy, pending_count, overflow};
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL rstmid_pre k=%0d got %b expected %b", k, obs, exp_vec);
      end
    end
    n_tests++;
    if (led_out !== 1'b1 || pending_count !== 2'd2) begin
      n_fail++;
      $display("FAIL rstmid_setup got led=%b pend=%0d expected led=1 pend=2", led_out, pending_count);
    end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if ({led_out, busy, pending_count} !== 4'b0) begin
      n_fail++;
      $display("FAIL rstmid_async got %b expected 0000", {led_out, busy, pending_count});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 15; k++) begin
      step(k == 3, 1'b0);
      obs = {led_out, busy, pending_count, overflow};
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL rstmid_post k=%0d got %b expected %b", k, obs, exp_vec);
      end
      if (led_out === 1'b1) led_cycles++;
    end
    n_tests++;
    if (led_cycles != ON) begin
      n_fail++;
      $display("FAIL rstmid_full_pulse got %0d expected %0d", led_cycles, ON);
    end
  endtask

  task automatic test_final_gap();
    logic [63:0] pat = 64'h10054;
    logic [4:0]  obs;
    for (int k = 0; k < 40; k++) begin
      step(pat[k], 1'b0);
      obs = {led_out, busy, pending_count, overflow};
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL final_gap k=%0d got %b expected %b", k, obs, exp_vec);
      end
      if (k == 16 || k == 17) begin
        n_tests++;
        if (led_out !== (k == 17) || pending_count !== 2'd1 || overflow !== 1'b0) begin
          n_fail++;
          $display("FAIL final_gap_restart k=%0d got led=%b pend=%0d ovf=%b expected led=%b pend=1 ovf=0",
                   k, led_out, pending_count, overflow, (k == 17));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] obs;
    logic       e;
    logic       c;
    for (int k = 0; k < 800; k++) begin
      e = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 15) == 0);
      step(e, c);
      obs = {led_out, busy, pending_count, overflow};
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL random k=%0d got %b expected %b", k, obs, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_queue();
    test_saturation();
    test_held();
    test_reset_mid();
    test_final_gap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
